// File: rtl/psum_axis_out_fifo.sv
// Buffers packed psum words from the bit-packer and drives them onto an AXI4-Stream master.
// Latency: a word pushed into an empty FIFO is presented one cycle later (registered FWFT).
// Backpressure: held by TREADY at the output; the input cannot stall, so pushes into a full FIFO are dropped and flagged.
module psum_axis_out_fifo #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  // Bits needed to index FIFO_DEPTH-1; equal to log2 of the depth for a power of 2.
  localparam int ADDR_W              = $clog2(FIFO_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_data,
  input  logic                                in_last,
  output logic                                m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [ADDR_W:0]                     fifo_level,
  output logic                                overflow,
  output logic                                frame_done
);

  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FIFO_DEPTH);

  // Entry = {last, data}. Storage holds every buffered word, including the
  // one currently mirrored in the output registers.
  logic [W:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   count, count_nxt;

  logic       push_req, push_acc, pop, drained;
  logic [W:0] push_word;
  logic [W:0] head_nxt;
  logic       tvalid_nxt;

  assign m_axis_tstrb = '1;
  assign fifo_level   = count;

  // Push/pop decode; a lone last becomes a zero flush word that closes the DMA frame.
  always_comb begin
    push_req  = in_valid | in_last;
    push_word = in_valid ? {in_last, in_data} : {1'b1, {W{1'b0}}};
    pop       = m_axis_tvalid & m_axis_tready;
    push_acc  = push_req & ((count != DEPTH_L) | pop);
    // True when the pop (if any) leaves no older word behind the head.
    drained   = (count == {{ADDR_W{1'b0}}, pop});
  end

  // Next level, read pointer and head word for the registered output stage.
  always_comb begin
    count_nxt = count;
    if (push_acc && !pop)
      count_nxt = count + 1'b1;
    else if (!push_acc && pop)
      count_nxt = count - 1'b1;

    rd_ptr_nxt = rd_ptr + ADDR_W'(pop);
    tvalid_nxt = (count_nxt != '0);

    // Default holds the output stable; only refreshed when a head exists.
    head_nxt = {m_axis_tlast, m_axis_tdata};
    if (tvalid_nxt) begin
      if (drained)
        head_nxt = push_word;        // new word lands on an otherwise empty FIFO
      else
        head_nxt = mem[rd_ptr_nxt];  // next older word already in storage
    end
  end

  // Storage write; contents need no reset since level/pointers gate their use.
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= push_word;
  end

  // Pointers, level, output registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      m_axis_tvalid <= tvalid_nxt;
      {m_axis_tlast, m_axis_tdata} <= head_nxt;
      if (push_req && !push_acc)
        overflow <= 1'b1;
      frame_done    <= pop & m_axis_tlast;
    end
  end

endmodule

// File: tb/tb_psum_axis_out_fifo.sv
// Directed and randomized checks of the psum AXIS output FIFO.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Ends with a single summary line of vectors applied and miscompares.
module tb_psum_axis_out_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  psum_axis_out_fifo #(.C_M_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .fifo_level(fifo_level),
    .overflow(overflow), .frame_done(frame_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    in_valid = 0; in_data = '0; in_last = 0; m_axis_tready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    in_valid = 0; in_data = '0; in_last = 0; m_axis_tready = 0;
    rst_n = 0;
    #3;
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, overflow, frame_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got tvalid/tlast/ovf/fd=%b want 0000",
               {m_axis_tvalid, m_axis_tlast, overflow, frame_done});
    end
    vectors++;
    if (fifo_level !== 5'd0 || m_axis_tdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_level_data: got level=%0d tdata=%h want 0/0", fifo_level, m_axis_tdata);
    end
    vectors++;
    if (m_axis_tstrb !== 4'hF) begin
      miscompares++;
      $display("FAIL tstrb: got %h want f", m_axis_tstrb);
    end
    apply_reset();
  endtask

  task automatic test_single_word;
    m_axis_tready = 1;
    in_valid = 1; in_data = 32'hA5A5_0001; in_last = 0;
    tick();
    in_valid = 0; in_data = '0;
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA5A5_0001 || m_axis_tlast !== 1'b0 || fifo_level !== 5'd1) begin
      miscompares++;
      $display("FAIL single_present: got v=%b d=%h l=%b lvl=%0d want 1 a5a50001 0 1",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level);
    end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got v=%b lvl=%0d fd=%b want 0 0 0", m_axis_tvalid, fifo_level, frame_done);
    end
  endtask

  task automatic fill_16;
    m_axis_tready = 0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1; in_data = i; in_last = 0;
      tick();
    end
    in_valid = 0; in_data = '0;
  endtask

  task automatic test_burst_backpressure;
    fill_16();
    vectors++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0 || m_axis_tdata !== 32'h1 || m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_full: got lvl=%0d ovf=%b d=%h v=%b want 16 0 1 1",
               fifo_level, overflow, m_axis_tdata, m_axis_tvalid);
    end
    tick();
    vectors++;
    if (m_axis_tdata !== 32'h1 || m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_hold: got d=%h v=%b want 1 1", m_axis_tdata, m_axis_tvalid);
    end
    m_axis_tready = 1;
    for (int i = 1; i <= 16; i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== i) begin
        miscompares++;
        $display("FAIL burst_beat%0d: got v=%b d=%h want 1 %h", i, m_axis_tvalid, m_axis_tdata, i);
      end
      tick();
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd0) begin
      miscompares++;
      $display("FAIL burst_empty: got v=%b lvl=%0d want 0 0", m_axis_tvalid, fifo_level);
    end
  endtask

  task automatic test_overflow;
    fill_16();
    in_valid = 1; in_data = 32'hDEAD;
    tick();
    in_valid = 0; in_data = '0;
    vectors++;
    if (overflow !== 1'b1 || fifo_level !== 5'd16 || m_axis_tdata !== 32'h1) begin
      miscompares++;
      $display("FAIL ovf_drop: got ovf=%b lvl=%0d d=%h want 1 16 1", overflow, fifo_level, m_axis_tdata);
    end
    // Full with a pop in the same cycle: the push must be taken.
    m_axis_tready = 1;
    in_valid = 1; in_data = 32'hBEEF;
    tick();
    in_valid = 0; in_data = '0;
    vectors++;
    if (fifo_level !== 5'd16 || m_axis_tdata !== 32'h2) begin
      miscompares++;
      $display("FAIL ovf_push_pop: got lvl=%0d d=%h want 16 2", fifo_level, m_axis_tdata);
    end
    for (int i = 2; i <= 16; i++) tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hBEEF) begin
      miscompares++;
      $display("FAIL ovf_tail: got v=%b d=%h want 1 beef", m_axis_tvalid, m_axis_tdata);
    end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got v=%b ovf=%b want 0 1", m_axis_tvalid, overflow);
    end
    apply_reset();
  endtask

  task automatic test_last_with_data;
    m_axis_tready = 1;
    in_valid = 1; in_data = 32'h7; in_last = 1;
    tick();
    in_valid = 0; in_data = '0; in_last = 0;
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h7 || m_axis_tlast !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL last_beat: got v=%b d=%h l=%b fd=%b want 1 7 1 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, frame_done);
    end
    tick();
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL last_fd_pulse: got %b want 1", frame_done);
    end
    tick();
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL last_fd_clear: got %b want 0", frame_done);
    end
  endtask

  task automatic test_lone_last;
    logic [32:0] exp [3];
    exp[0] = {1'b0, 32'h3}; exp[1] = {1'b0, 32'h4}; exp[2] = {1'b1, 32'h0};
    m_axis_tready = 0;
    in_valid = 1; in_data = 32'h3; tick();
    in_data = 32'h4; tick();
    in_valid = 0; in_data = 32'hFFFF_FFFF; in_last = 1; tick();
    in_last = 0; in_data = '0;
    vectors++;
    if (fifo_level !== 5'd3) begin
      miscompares++;
      $display("FAIL lone_level: got %0d want 3", fifo_level);
    end
    m_axis_tready = 1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== exp[i] || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL lone_beat%0d: got v=%b l=%b d=%h fd=%b want 1 %b %h 0", i,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_done, exp[i][32], exp[i][31:0]);
      end
      tick();
    end
    vectors++;
    if (frame_done !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL lone_fd: got fd=%b v=%b want 1 0", frame_done, m_axis_tvalid);
    end
    tick();
  endtask

  task automatic test_random_and_reset;
    logic [32:0] q [$];
    logic [32:0] word;
    logic        exp_ovf;
    logic        exp_fd;
    logic        do_pop;
    logic        do_push;
    int          pushes;
    int          cyc;
    exp_ovf = 0; exp_fd = 0; pushes = 0; cyc = 0;
    while (pushes < 200 && cyc < 4000) begin
      vectors++;
      if (fifo_level !== 5'(q.size()) || m_axis_tvalid !== (q.size() != 0) ||
          overflow !== exp_ovf || frame_done !== exp_fd) begin
        miscompares++;
        $display("FAIL rand_state cyc%0d: got lvl=%0d v=%b ovf=%b fd=%b want %0d %b %b %b", cyc,
                 fifo_level, m_axis_tvalid, overflow, frame_done, q.size(), q.size() != 0, exp_ovf, exp_fd);
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      do_pop = (q.size() != 0) && m_axis_tready;
      exp_fd = 0;
      if (do_pop) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== q[0]) begin
          miscompares++;
          $display("FAIL rand_beat cyc%0d: got l=%b d=%h want %b %h", cyc,
                   m_axis_tlast, m_axis_tdata, q[0][32], q[0][31:0]);
        end
        exp_fd = q[0][32];
      end
      do_push = ($urandom_range(0, 2) == 0);
      in_valid = 0; in_last = 0; in_data = $urandom;
      word = '0;
      if (do_push) begin
        pushes++;
        if ($urandom_range(0, 7) == 0) begin
          in_last = 1;
          word = {1'b1, 32'h0};
        end else begin
          in_valid = 1;
          in_last = ($urandom_range(0, 7) == 0);
          word = {in_last, in_data};
        end
        if (q.size() < 16 || do_pop) q.push_back(word);
        else exp_ovf = 1;
      end
      if (do_pop) void'(q.pop_front());
      tick();
      cyc++;
    end
    in_valid = 0; in_last = 0;
    vectors++;
    if (pushes != 200) begin
      miscompares++;
      $display("FAIL rand_budget: got %0d pushes want 200", pushes);
    end
    // Leave words buffered, then reset between clock edges.
    m_axis_tready = 0;
    in_valid = 1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b lvl=%0d ovf=%b want 0 0 0", m_axis_tvalid, fifo_level, overflow);
    end
    apply_reset();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd0) begin
      miscompares++;
      $display("FAIL post_reset_empty: got v=%b lvl=%0d want 0 0", m_axis_tvalid, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_backpressure();
    test_overflow();
    test_last_with_data();
    test_lone_last();
    test_random_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_axis_out_fifo.md
Name: psum_axis_out_fifo

Overview:
- Downstream neighbour of the psum bit-packer.
- Takes packed 32-bit psum words (valid/data/last pulses, no backpressure) and buffers them in a FIFO.
- Drives them onto an AXI4-Stream master toward the output DMA, honouring TREADY.
- Handles the packer's quirk of asserting last with or without a data beat. Reports overflow and frame completion.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, width of in_data and m_axis_tdata.
- FIFO_DEPTH, 16, number of entries. Must be a power of 2, minimum 4.
- ADDR_W, clogb2(FIFO_DEPTH-1), pointer/index width (derived, not to be overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  packed word present on in_data this cycle.
- in_data  in  C_M_AXIS_TDATA_WIDTH  packed psum word.
- in_last  in  1  end of layer; may coincide with in_valid or arrive alone.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  AXIS data.
- m_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  AXIS byte strobe, always all ones.
- m_axis_tlast  out  1  AXIS last.
- m_axis_tready  in  1  AXIS ready from DMA.
- fifo_level  out  ADDR_W+1  entries held, including the one currently presented.
- overflow  out  1  sticky: a push was dropped.
- frame_done  out  1  one-cycle pulse after a beat with tlast is accepted.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All pointers, count, m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow and frame_done reset to 0. Storage contents are don't-care.
- Entry format: {last, data}, C_M_AXIS_TDATA_WIDTH+1 bits.
- Push request (push_req), one per cycle at most:
  - in_valid=1: push {in_last, in_data}.
  - in_valid=0, in_last=1: push {1, 0}, a zero flush word that terminates the DMA frame.
  - Otherwise no push.
- Pop: occurs when m_axis_tvalid & m_axis_tready.
- Accept condition: a push is accepted when level < FIFO_DEPTH, or when level == FIFO_DEPTH and a pop occurs in the same cycle.
- Full drop: otherwise the word is dropped, overflow is set to 1 and stays 1 until reset. The FIFO contents are unchanged.
- Output timing:
  - Registered, first-word-fall-through.
  - A word pushed into an empty FIFO at edge T appears with m_axis_tvalid=1 at T+1 (one-cycle latency).
  - Sustained throughput is 1 beat/cycle while tready=1 and data is available.
- AXIS stability: while m_axis_tvalid=1 and tready=0, tdata and tlast are held stable. tvalid never deasserts without a pop.
- Simultaneous push and pop: level is unchanged. Push on empty combined with pop is impossible (tvalid=0 when empty).
- Wrap-around: read and write pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. Level is tracked as a separate counter, 0..FIFO_DEPTH.
- frame_done: 1 in the cycle after a pop whose tlast=1, otherwise 0.
- m_axis_tstrb is a constant all-ones.
- Reset mid-frame: all buffered words are discarded and outputs return to their reset values immediately (asynchronously).
- Implementation: no combinational path from m_axis_tready to m_axis_tvalid, tdata or tlast.

Test Plan:
- Single word: in_valid=1, in_data=0xA5A5_0001, in_last=0 with tready=1 -> next cycle tvalid=1, tdata=0xA5A5_0001, tlast=0. fifo_level goes 1 then 0. frame_done stays 0.
- Burst with backpressure: push 0x1..0x10 on 16 consecutive cycles with tready=0 -> fifo_level=16, overflow=0. Raise tready -> beats 0x1..0x10 in order on consecutive cycles. tdata holds 0x1 while tready=0.
- Overflow: with FIFO full (16 entries) and tready=0, push 0xDEAD -> dropped, overflow=1 and sticky. The 17th beat never appears. With FIFO full and tready=1, a push in the same cycle is accepted and level stays 16.
- Last with data: push 0x7 with in_last=1 -> beat tdata=0x7, tlast=1. frame_done=1 for exactly one cycle after acceptance.
- Lone last: in_last=1, in_valid=0 after words 0x3 and 0x4 -> beats 0x3 (tlast=0), 0x4 (tlast=0), 0x0 (tlast=1). Then frame_done pulses.
- Random tready (50%) with 200 random pushes at ≤50% rate: scoreboard order and data match, and no overflow. Then assert rst_n=0 mid-stream -> tvalid=0 and fifo_level=0 immediately, overflow=0.
